instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Small instruction store plus a sequential fetch engine. Words are loaded
// through the write port while the engine is idle (LOAD or HALT). Once started,
// it walks the store word by word from byte address 0. Each fetched word is
// registered on `instruction` together with its byte address. A fetch that
// reads an all-zero word is the end-of-program marker and parks the engine in
// HALT.
//
// Handshake: `enable` is a plain advance/stall qualifier, not valid/ready.
// `valid` is a one-cycle pulse that is high in exactly the cycle after an edge
// which loaded a new word into `instruction`. It is low after stalls, after
// the start edge, and after the end-of-program fetch.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : asynchronous, active-low reset
//   wr_en          : write strobe, honoured in LOAD and HALT only
//   wr_addr        : word index to write
//   wr_data        : instruction word to write
//   start          : begin fetching at byte address 0 (from LOAD or HALT)
//   enable         : 1 = advance the fetch, 0 = stall
//   instruction    : registered fetched word
//   instr_addr     : byte address of the word on `instruction`
//   opcode, rs, rt, rd, shamt, function_code, imm : fields sliced from `instruction`
//   valid          : `instruction` holds a newly fetched word this cycle
//   halted         : engine is in HALT
//   state_o        : debug view of the FSM state (0 = LOAD, 1 = RUN, 2 = HALT)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              start,
    input  logic              enable,
    output logic [31:0]       instruction,
    output logic [31:0]       instr_addr,
    output logic [5:0]        opcode,
    output logic [5:0]        function_code,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       imm,
    output logic              valid,
    output logic              halted,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Byte address of the last word; the fetch pointer wraps to 0 after it.
    localparam logic [31:0] LAST_ADDR = 32'(4 * (MEM_DEPTH - 1));

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;

    logic [31:0]       mem_q [MEM_DEPTH];
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       rd_word;
    logic              mem_we;

    assign rd_idx  = pc_q[ADDR_W+1:2];
    assign rd_word = mem_q[rd_idx];
    // The write port is locked out while fetching so the program cannot
    // change underneath the engine.
    assign mem_we  = wr_en && (state_q != ST_RUN);

    // Instruction store. Reset only blocks writes while asserted; it never
    // clears the contents, so a program survives a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
        end else if (mem_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            pc_q    <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        case (state_q)
            ST_LOAD, ST_HALT: begin
                // A write on the same edge as start lands before the first
                // fetch edge, so the first fetch sees the new word.
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (rd_word == 32'h0000_0000) begin
                        // End-of-program marker: keep the last good word on
                        // the outputs and leave pc pointing at the marker.
                        state_d = ST_HALT;
                    end else begin
                        instr_d = rd_word;
                        addr_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = (pc_q == LAST_ADDR) ? 32'd0 : pc_q + 32'd4;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign instruction   = instr_q;
    assign instr_addr    = addr_q;
    assign valid         = valid_q;
    assign halted        = (state_q == ST_HALT);
    assign state_o       = state_q;

    assign opcode        = instr_q[31:26];
    assign rs            = instr_q[25:21];
    assign rt            = instr_q[20:16];
    assign rd            = instr_q[15:11];
    assign shamt         = instr_q[10:6];
    assign function_code = instr_q[5:0];
    assign imm           = instr_q[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic        enable;
  logic [31:0] instruction, instr_addr;
  logic [5:0]  opcode, function_code;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic        valid, halted;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;

  // expected fetches: {instr_addr, instruction}
  logic [63:0] exp_q[$];

  instruction_fetch_unit #(.MEM_DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .enable(enable),
    .instruction(instruction), .instr_addr(instr_addr), .opcode(opcode),
    .function_code(function_code), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .valid(valid), .halted(halted), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic st, input logic en, input logic we,
                      input logic [3:0] wa, input logic [31:0] wd);
    start = st; enable = en; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fetch_unexpected: got addr=%h instr=%h, required no fetch",
                   instr_addr, instruction);
        end else begin
          e = exp_q.pop_front();
          if ({instr_addr, instruction} !== e) begin
            errors++;
            $display("FAIL fetch_data: got addr=%h instr=%h, required addr=%h instr=%h",
                     instr_addr, instruction, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        st;
    logic        en;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        exp_valid;
    logic        exp_halted;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [5:0]  exp_opcode;
    logic [5:0]  exp_func;
    logic [15:0] exp_imm;
  } vec_t;

  vec_t        vec [5];
  logic [31:0] pb [7];
  logic [31:0] wv [16];
  logic [31:0] w;

  initial begin
    // start together with the write of word 0: the first fetch must see it
    vec[0] = '{st:1'b1, en:1'b1, we:1'b1, wa:4'd0, wd:32'h0000_0020, exp_valid:1'b0,
               exp_halted:1'b0, exp_addr:32'h0, exp_instr:32'h0, exp_opcode:6'h00,
               exp_func:6'h00, exp_imm:16'h0000};
    vec[1] = '{st:1'b0, en:1'b1, we:1'b0, wa:4'd0, wd:32'h0, exp_valid:1'b1,
               exp_halted:1'b0, exp_addr:32'h0, exp_instr:32'h0000_0020, exp_opcode:6'h00,
               exp_func:6'h20, exp_imm:16'h0020};
    vec[2] = '{st:1'b0, en:1'b1, we:1'b0, wa:4'd0, wd:32'h0, exp_valid:1'b1,
               exp_halted:1'b0, exp_addr:32'h4, exp_instr:32'hFC01_0005, exp_opcode:6'h3F,
               exp_func:6'h05, exp_imm:16'h0005};
    vec[3] = '{st:1'b0, en:1'b1, we:1'b0, wa:4'd0, wd:32'h0, exp_valid:1'b0,
               exp_halted:1'b1, exp_addr:32'h4, exp_instr:32'hFC01_0005, exp_opcode:6'h3F,
               exp_func:6'h05, exp_imm:16'h0005};
    vec[4] = '{st:1'b0, en:1'b1, we:1'b0, wa:4'd0, wd:32'h0, exp_valid:1'b0,
               exp_halted:1'b1, exp_addr:32'h4, exp_instr:32'hFC01_0005, exp_opcode:6'h3F,
               exp_func:6'h05, exp_imm:16'h0005};

    for (int i = 0; i < 6; i++) pb[i] = 32'h1111_0000 * (i + 1) + i;
    pb[6] = 32'h0;

    // ---------- reset ----------
    reset = 1'b0; start = 0; enable = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_instr_addr", instr_addr, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_state", {30'b0, state_o}, 32'd0);
    reset = 1'b1;

    // ---------- load and run (table) ----------
    step(0, 0, 1, 4'd1, 32'hFC01_0005);
    step(0, 0, 1, 4'd2, 32'h0);
    chk("load_stays_load", {30'b0, state_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (vec[i].exp_valid) expect_fetch(vec[i].exp_addr, vec[i].exp_instr);
      step(vec[i].st, vec[i].en, vec[i].we, vec[i].wa, vec[i].wd);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vec[i].exp_valid});
      chk($sformatf("vec%0d_halted", i), {31'b0, halted}, {31'b0, vec[i].exp_halted});
      chk($sformatf("vec%0d_addr", i), instr_addr, vec[i].exp_addr);
      chk($sformatf("vec%0d_instr", i), instruction, vec[i].exp_instr);
      chk($sformatf("vec%0d_opcode", i), {26'b0, opcode}, {26'b0, vec[i].exp_opcode});
      chk($sformatf("vec%0d_func", i), {26'b0, function_code}, {26'b0, vec[i].exp_func});
      chk($sformatf("vec%0d_imm", i), {16'b0, imm}, {16'b0, vec[i].exp_imm});
    end

    // ---------- restart from HALT ----------
    step(1, 0, 0, 4'd0, 32'h0);
    chk("restart_halted", {31'b0, halted}, 32'h0);
    chk("restart_state", {30'b0, state_o}, 32'd1);
    chk("restart_valid", {31'b0, valid}, 32'h0);
    expect_fetch(32'h0, 32'h0000_0020);
    step(0, 1, 0, 4'd0, 32'h0);
    chk("restart_fetch_valid", {31'b0, valid}, 32'h1);
    chk("restart_fetch_addr", instr_addr, 32'h0);
    expect_fetch(32'h4, 32'hFC01_0005);
    step(0, 1, 0, 4'd0, 32'h0);
    step(0, 1, 0, 4'd0, 32'h0);
    chk("restart_rehalt", {31'b0, halted}, 32'h1);

    // ---------- load program B while halted ----------
    for (int i = 0; i < 7; i++) step(0, 0, 1, 4'(i), pb[i]);
    chk("halt_load_no_fetch", {31'b0, valid}, 32'h0);
    chk("halt_load_state", {30'b0, state_o}, 32'd2);

    // ---------- stall, writes while running, start while running ----------
    step(1, 0, 0, 4'd0, 32'h0);
    expect_fetch(32'h0, pb[0]);
    step(0, 1, 1, 4'd1, 32'hDEAD_0001);     // write to mem[1] while running
    expect_fetch(32'h4, pb[1]);
    step(0, 1, 1, 4'd2, 32'hDEAD_0002);     // write to mem[2] while running
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 4'd0, 32'h0);
      chk($sformatf("stall%0d_valid", i), {31'b0, valid}, 32'h0);
      chk($sformatf("stall%0d_addr", i), instr_addr, 32'h4);
      chk($sformatf("stall%0d_instr", i), instruction, pb[1]);
    end
    expect_fetch(32'h8, pb[2]);
    step(0, 1, 0, 4'd0, 32'h0);
    chk("resume_addr", instr_addr, 32'h8);
    chk("resume_instr", instruction, pb[2]);
    expect_fetch(32'hC, pb[3]);
    step(1, 1, 0, 4'd0, 32'h0);             // start ignored in RUN
    chk("start_in_run_addr", instr_addr, 32'hC);
    expect_fetch(32'h10, pb[4]);
    step(0, 1, 0, 4'd0, 32'h0);
    expect_fetch(32'h14, pb[5]);
    step(0, 1, 0, 4'd0, 32'h0);
    step(0, 1, 0, 4'd0, 32'h0);
    chk("b_halted", {31'b0, halted}, 32'h1);
    chk("b_halt_valid", {31'b0, valid}, 32'h0);
    chk("b_halt_addr", instr_addr, 32'h14);
    chk("b_halt_instr", instruction, pb[5]);

    // ---------- reset mid-run ----------
    step(1, 0, 0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      expect_fetch(32'(4 * i), pb[i]);
      step(0, 1, 0, 4'd0, 32'h0);
    end
    chk("pre_reset_addr", instr_addr, 32'h8);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_instruction", instruction, 32'h0);
    chk("async_rst_addr", instr_addr, 32'h0);
    chk("async_rst_valid", {31'b0, valid}, 32'h0);
    chk("async_rst_state", {30'b0, state_o}, 32'd0);
    step(1, 1, 1, 4'd0, 32'hBAD0_BAD0);     // edge while in reset: nothing happens
    chk("held_rst_state", {30'b0, state_o}, 32'd0);
    chk("held_rst_addr", instr_addr, 32'h0);
    chk("held_rst_valid", {31'b0, valid}, 32'h0);
    reset = 1'b1;
    step(1, 0, 0, 4'd0, 32'h0);
    chk("post_rst_state", {30'b0, state_o}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      expect_fetch(32'(4 * i), pb[i]);
      step(0, 1, 0, 4'd0, 32'h0);
      chk($sformatf("refetch%0d_instr", i), instruction, pb[i]);
    end
    step(0, 1, 0, 4'd0, 32'h0);
    chk("refetch_halted", {31'b0, halted}, 32'h1);

    // ---------- wrap ----------
    for (int i = 0; i < 16; i++) begin
      wv[i] = $urandom() | 32'h1;
      step(0, 0, 1, 4'(i), wv[i]);
    end
    step(1, 0, 0, 4'd0, 32'h0);
    for (int k = 0; k < 18; k++) begin
      expect_fetch(32'(4 * (k % 16)), wv[k % 16]);
      step(0, 1, 0, 4'd0, 32'h0);
      chk($sformatf("wrap%0d_addr", k), instr_addr, 32'(4 * (k % 16)));
    end
    w = wv[1];
    chk("field_opcode", {26'b0, opcode}, {26'b0, w[31:26]});
    chk("field_rs", {27'b0, rs}, {27'b0, w[25:21]});
    chk("field_rt", {27'b0, rt}, {27'b0, w[20:16]});
    chk("field_rd", {27'b0, rd}, {27'b0, w[15:11]});
    chk("field_shamt", {27'b0, shamt}, {27'b0, w[10:6]});
    chk("field_func", {26'b0, function_code}, {26'b0, w[5:0]});
    chk("field_imm", {16'b0, imm}, {16'b0, w[15:0]});

    step(0, 0, 0, 4'd0, 32'h0);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
